// File: rtl/spike_gen_scheduler.sv
// Time-multiplexed spike generator scheduler: scans a table of periodic generators per time unit.
// Optional macro SG_OVERRUN_COUNT_EN builds a saturating counter of merged (lost) ticks.
module spike_gen_scheduler #(
    parameter int unsigned N_SG_gens   = 8,
    parameter int unsigned N_SG_period = 16,
    parameter int unsigned N_SG_tag    = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      prog_v,
    output logic                      prog_a,
    input  logic [N_SG_gens-1:0]      prog_gen_idx,
    input  logic [N_SG_period-1:0]    prog_period,
    input  logic [N_SG_period-1:0]    prog_ticks,
    input  logic [N_SG_tag-1:0]       prog_tag,
    input  logic                      prog_sign,
    input  logic [N_SG_gens-1:0]      gens_used,
    input  logic [2**N_SG_gens-1:0]   gens_en,
    input  logic                      time_unit_tick,
    output logic                      out_v,
    input  logic                      out_a,
    output logic [N_SG_tag-1:0]       out_tag,
    output logic                      out_sign,
    output logic                      busy,
    output logic [15:0]               overrun_count
);
    localparam int unsigned Depth = 2**N_SG_gens;

    typedef enum logic [1:0] {StIdle, StRd, StUpd, StEmit} state_t;

    state_t                 state_q, state_d;
    logic                   pending_q;
    logic [N_SG_gens-1:0]   idx_q, idx_d, idx_last;
    logic [N_SG_tag-1:0]    tag_q;
    logic                   sign_q;

    logic [N_SG_period-1:0] period_mem [Depth];
    logic [N_SG_period-1:0] ticks_mem  [Depth];
    logic [N_SG_tag-1:0]    tag_mem    [Depth];
    logic                   sign_mem   [Depth];

    logic [N_SG_period-1:0] rd_period, rd_ticks;
    logic [N_SG_tag-1:0]    rd_tag;
    logic                   rd_sign;

    logic                   prog_we, upd_we, latch_en, pend_clr, advance;
    logic [N_SG_period-1:0] upd_ticks;

    assign idx_last = gens_used - N_SG_gens'(1);

    // Table storage is deliberately not reset; entries are undefined until programmed.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            period_mem[prog_gen_idx] <= prog_period;
            ticks_mem[prog_gen_idx]  <= prog_ticks;
            tag_mem[prog_gen_idx]    <= prog_tag;
            sign_mem[prog_gen_idx]   <= prog_sign;
        end else if (upd_we) begin
            ticks_mem[idx_q] <= upd_ticks;
        end
        if (state_q == StRd) begin
            rd_period <= period_mem[idx_q];
            rd_ticks  <= ticks_mem[idx_q];
            rd_tag    <= tag_mem[idx_q];
            rd_sign   <= sign_mem[idx_q];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        prog_a    = 1'b0;
        prog_we   = 1'b0;
        upd_we    = 1'b0;
        upd_ticks = rd_ticks - N_SG_period'(1);
        latch_en  = 1'b0;
        pend_clr  = 1'b0;
        advance   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (prog_v && !reset) begin
                    prog_a  = 1'b1;
                    prog_we = 1'b1;
                end else if (pending_q) begin
                    pend_clr = 1'b1;
                    if (gens_used != '0) begin
                        idx_d   = '0;
                        state_d = StRd;
                    end
                end
            end
            StRd: state_d = StUpd;
            StUpd: begin
                if (!gens_en[idx_q] || rd_period == '0) begin
                    advance = 1'b1;
                end else if (rd_ticks <= N_SG_period'(1)) begin
                    upd_we    = 1'b1;
                    upd_ticks = rd_period;
                    latch_en  = 1'b1;
                    state_d   = StEmit;
                end else begin
                    upd_we  = 1'b1;
                    advance = 1'b1;
                end
            end
            StEmit: advance = out_a;
            default: state_d = StIdle;
        endcase
        if (advance) begin
            if (idx_q == idx_last) begin
                state_d = StIdle;
            end else begin
                idx_d   = idx_q + N_SG_gens'(1);
                state_d = StRd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            // A new tick wins over the clear issued at scan start.
            if (time_unit_tick) begin
                pending_q <= 1'b1;
            end else if (pend_clr) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            tag_q  <= rd_tag;
            sign_q <= rd_sign;
        end
    end

    assign out_v    = (state_q == StEmit);
    assign out_tag  = tag_q;
    assign out_sign = sign_q;
    assign busy     = (state_q != StIdle);

`ifdef SG_OVERRUN_COUNT_EN
    logic        overrun;
    logic [15:0] ovr_cnt_q;

    assign overrun = time_unit_tick && pending_q && !pend_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_cnt_q <= '0;
        end else if (overrun && ovr_cnt_q != 16'hFFFF) begin
            ovr_cnt_q <= ovr_cnt_q + 16'd1;
        end
    end

    assign overrun_count = ovr_cnt_q;
`else
    assign overrun_count = 16'd0;
`endif

endmodule

// File: tb/tb_spike_gen_scheduler.sv
// Directed self-checking bench for spike_gen_scheduler (default parameters).
module tb_spike_gen_scheduler;
    logic         clk = 1'b0;
    logic         reset;
    logic         prog_v;
    logic         prog_a;
    logic [7:0]   prog_gen_idx;
    logic [15:0]  prog_period;
    logic [15:0]  prog_ticks;
    logic [10:0]  prog_tag;
    logic         prog_sign;
    logic [7:0]   gens_used;
    logic [255:0] gens_en;
    logic         time_unit_tick;
    logic         out_v;
    logic         out_a;
    logic [10:0]  out_tag;
    logic         out_sign;
    logic         busy;
    logic [15:0]  overrun_count;

    int n_cmp = 0;
    int n_fail = 0;
    int spike_cnt = 0;
    logic [10:0] last_tag = '0;
    logic        last_sign = 1'b0;

    spike_gen_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .prog_v        (prog_v),
        .prog_a        (prog_a),
        .prog_gen_idx  (prog_gen_idx),
        .prog_period   (prog_period),
        .prog_ticks    (prog_ticks),
        .prog_tag      (prog_tag),
        .prog_sign     (prog_sign),
        .gens_used     (gens_used),
        .gens_en       (gens_en),
        .time_unit_tick(time_unit_tick),
        .out_v         (out_v),
        .out_a         (out_a),
        .out_tag       (out_tag),
        .out_sign      (out_sign),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && out_v && out_a) begin
            spike_cnt = spike_cnt + 1;
            last_tag  = out_tag;
            last_sign = out_sign;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [7:0] idx, input logic [15:0] per, input logic [15:0] tk,
                        input logic [10:0] tg, input logic sg);
        prog_gen_idx = idx;
        prog_period  = per;
        prog_ticks   = tk;
        prog_tag     = tg;
        prog_sign    = sg;
        prog_v       = 1'b1;
        #1;
        chk("prog_a_idle", prog_a, 1);
        step();
        prog_v = 1'b0;
    endtask

    // Pulse one tick, then run until the scan ends; scan_cyc counts busy cycles outside EMIT.
    task automatic run_tick(output int scan_cyc);
        time_unit_tick = 1'b1;
        step();
        time_unit_tick = 1'b0;
        step();
        scan_cyc = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            if (!out_v) scan_cyc++;
            step();
        end
        chk("scan_timeout", busy, 0);
    endtask

    task automatic wait_out_v();
        for (int i = 0; i < 20 && !out_v; i++) step();
        chk("wait_out_v", out_v, 1);
    endtask

    initial begin
        int sc;
        int base;
        reset = 1'b1; prog_v = 1'b1; prog_gen_idx = '0; prog_period = '0; prog_ticks = '0;
        prog_tag = '0; prog_sign = 1'b0; gens_used = '0; gens_en = '0;
        time_unit_tick = 1'b0; out_a = 1'b1;
        repeat (3) step();
        chk("rst_out_v", out_v, 0);
        chk("rst_busy", busy, 0);
        chk("rst_prog_a", prog_a, 0);
        chk("rst_overrun", overrun_count, 0);
        prog_v = 1'b0;
        reset = 1'b0;
        step();

        // Gen 0 period 3, ticks 1: spikes after ticks 1, 4, 7.
        prog(8'd0, 16'd3, 16'd1, 11'h005, 1'b0);
        gens_used = 8'd1;
        gens_en[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            base = spike_cnt;
            run_tick(sc);
            chk($sformatf("p3_spike_t%0d", k), spike_cnt - base, (k % 3 == 1) ? 1 : 0);
        end
        chk("p3_tag", last_tag, 11'h005);
        chk("p3_sign", last_sign, 0);

        // Four generators, only gen 2 enabled with period 1.
        prog(8'd0, 16'd1, 16'd1, 11'h011, 1'b0);
        prog(8'd1, 16'd1, 16'd1, 11'h022, 1'b0);
        prog(8'd2, 16'd1, 16'd1, 11'h033, 1'b1);
        prog(8'd3, 16'd2, 16'd1, 11'h044, 1'b0);
        gens_used = 8'd4;
        gens_en = '0;
        gens_en[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            base = spike_cnt;
            last_tag = '0;
            run_tick(sc);
            chk("en2_spike", spike_cnt - base, 1);
            chk("en2_tag", last_tag, 11'h033);
            chk("en2_sign", last_sign, 1);
            chk("en2_scan_cycles", sc, 8);
        end

        // Gen 3 enabled but period 0 is skipped.
        prog(8'd3, 16'd0, 16'd1, 11'h044, 1'b0);
        gens_en[3] = 1'b1;
        base = spike_cnt;
        run_tick(sc);
        chk("p0_spike", spike_cnt - base, 1);
        chk("p0_tag", last_tag, 11'h033);
        gens_en[3] = 1'b0;

        // Output stall of 20 cycles with program requests and three ticks.
        prog(8'd0, 16'd1, 16'd1, 11'h2AA, 1'b1);
        gens_used = 8'd1;
        gens_en = '0;
        gens_en[0] = 1'b1;
        out_a = 1'b0;
        time_unit_tick = 1'b1;
        step();
        time_unit_tick = 1'b0;
        wait_out_v();
        prog_gen_idx = 8'd5; prog_period = 16'd7; prog_ticks = 16'd7;
        prog_tag = 11'h155; prog_sign = 1'b0;
        for (int c = 0; c < 20; c++) begin
            prog_v = 1'b1;
            time_unit_tick = (c == 3 || c == 8 || c == 13);
            #1;
            chk("stall_out_v", out_v, 1);
            chk("stall_tag", out_tag, 11'h2AA);
            chk("stall_sign", out_sign, 1);
            chk("stall_prog_a", prog_a, 0);
            step();
        end
        time_unit_tick = 1'b0;
        out_a = 1'b1;
        #1;
        chk("hs_out_v", out_v, 1);
        base = spike_cnt;
        step();
        chk("hs_spike", spike_cnt - base, 1);
        chk("hs_prog_a", prog_a, 1);
        chk("hs_busy", busy, 0);
        step();
        prog_v = 1'b0;
        base = spike_cnt;
        step();
        for (int i = 0; i < 50 && busy; i++) step();
        chk("ovr_scan_done", busy, 0);
        chk("ovr_one_scan", spike_cnt - base, 1);
        repeat (20) step();
        chk("ovr_no_more", spike_cnt - base, 1);
`ifdef SG_OVERRUN_COUNT_EN
        chk("overrun_count", overrun_count, 2);
`else
        chk("overrun_count", overrun_count, 0);
`endif

        // Reset during EMIT drops the held spike.
        out_a = 1'b0;
        time_unit_tick = 1'b1;
        step();
        time_unit_tick = 1'b0;
        wait_out_v();
        reset = 1'b1;
        step();
        chk("rstemit_out_v", out_v, 0);
        chk("rstemit_busy", busy, 0);
        reset = 1'b0;
        out_a = 1'b1;
        base = spike_cnt;
        repeat (20) step();
        chk("rstemit_no_spike", spike_cnt - base, 0);
        chk("rstemit_idle", busy, 0);
        run_tick(sc);
        chk("rstemit_next_spike", spike_cnt - base, 1);
        chk("rstemit_tag", last_tag, 11'h2AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
